// File: rtl/mem_ctrl_mp.sv
// Multi-channel memory controller: round-robin arbitration of NCH clients onto an
// 8-bit external bus, one byte per cycle, with IO write back-pressure and read abort on flush.
module mem_ctrl_mp #(
    parameter int unsigned     NCH        = 2,
    parameter int unsigned     DATA_W     = 32,
    parameter logic [NCH-1:0]  FLUSH_MASK = {NCH{1'b1}}
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   rdy,
    input  logic [NCH-1:0]                         req_valid,
    input  logic [NCH-1:0]                         req_wr,
    input  logic [NCH*32-1:0]                      req_addr,
    input  logic [NCH*DATA_W-1:0]                  req_data,
    input  logic [NCH*($clog2(DATA_W/8)+1)-1:0]    req_len,
    output logic [NCH-1:0]                         resp_done,
    output logic [DATA_W-1:0]                      resp_data,
    input  logic                                   flush,
    input  logic                                   io_buffer_full,
    input  logic [7:0]                             mem_din,
    output logic [7:0]                             mem_dout,
    output logic [31:0]                            mem_a,
    output logic                                   mem_wr
);

    localparam int unsigned NB = DATA_W / 8;
    localparam int unsigned LW = $clog2(NB) + 1;
    localparam int unsigned PW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [NCH-1:0] ONE = {{(NCH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_IOWAIT
    } state_t;

    state_t             state;
    logic [PW-1:0]      ptr;
    logic [PW-1:0]      ch;
    logic [31:0]        addr;
    logic [DATA_W-1:0]  data;
    logic [LW-1:0]      len;
    logic [LW-1:0]      cnt;
    logic [DATA_W-1:0]  rbuf;

    logic               gnt_found;
    logic [PW-1:0]      gnt_idx;
    logic               g_wr;
    logic [31:0]        g_addr;
    logic [DATA_W-1:0]  g_data;
    logic [LW-1:0]      g_len;
    logic               g_len_ok;
    logic [NCH-1:0]     elig;

    logic [LW-1:0]      cnt_inc;
    logic [LW-1:0]      sel_idx;
    logic [7:0]         sel_byte;
    logic [DATA_W-1:0]  rd_next;
    logic               is_io;

    // Round-robin search starting one past the last grantee; flushable channels sit out a flush cycle
    always_comb begin : arb
        int unsigned idx;
        idx       = 0;
        elig      = req_valid & ~(flush ? FLUSH_MASK : '0);
        gnt_found = 1'b0;
        gnt_idx   = '0;
        g_wr      = 1'b0;
        g_addr    = '0;
        g_data    = '0;
        g_len     = '0;
        for (int unsigned off = 1; off <= NCH; off++) begin
            idx = (32'(ptr) + off) % NCH;
            if (!gnt_found && elig[PW'(idx)]) begin
                gnt_found = 1'b1;
                gnt_idx   = PW'(idx);
                g_wr      = req_wr[PW'(idx)];
                g_addr    = 32'(req_addr >> (32 * idx));
                g_data    = DATA_W'(req_data >> (DATA_W * idx));
                g_len     = LW'(req_len >> (LW * idx));
            end
        end
        g_len_ok = (g_len != '0) && (g_len <= LW'(NB));
    end

    // Byte steering for the read accumulator and the write data path
    always_comb begin
        cnt_inc = LW'(cnt + LW'(1));
        rd_next = rbuf;
        for (int unsigned b = 0; b < NB; b++) begin
            if (cnt == LW'(b + 1)) begin
                rd_next[8*b +: 8] = mem_din;
            end
        end
        sel_idx  = (state == ST_IOWAIT) ? cnt : cnt_inc;
        sel_byte = 8'(data >> (8 * sel_idx));
        is_io    = (addr[17:16] == 2'b11);
    end

    // In RD, cnt is the byte whose address is on the bus (cnt==len is the trailing data cycle);
    // in WR it is the byte being written; in IOWAIT it is the next byte to write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            ptr       <= PW'(NCH - 1);
            ch        <= '0;
            addr      <= '0;
            data      <= '0;
            len       <= '0;
            cnt       <= '0;
            rbuf      <= '0;
            mem_a     <= '0;
            mem_dout  <= '0;
            mem_wr    <= 1'b0;
            resp_done <= '0;
            resp_data <= '0;
        end else if (rdy) begin
            resp_done <= '0;
            case (state)
                ST_IDLE: begin
                    mem_a    <= '0;
                    mem_dout <= '0;
                    mem_wr   <= 1'b0;
                    if (gnt_found) begin
                        ptr  <= gnt_idx;
                        ch   <= gnt_idx;
                        addr <= g_addr;
                        data <= g_data;
                        len  <= g_len;
                        cnt  <= '0;
                        rbuf <= '0;
                        if (!g_len_ok) begin
                            resp_done <= ONE << gnt_idx;
                            resp_data <= '0;
                        end else if (!g_wr) begin
                            state <= ST_RD;
                            mem_a <= g_addr;
                        end else if ((g_addr[17:16] == 2'b11) && io_buffer_full) begin
                            state <= ST_IOWAIT;
                        end else begin
                            state    <= ST_WR;
                            mem_a    <= g_addr;
                            mem_dout <= g_data[7:0];
                            mem_wr   <= 1'b1;
                        end
                    end
                end

                ST_RD: begin
                    if (flush && FLUSH_MASK[ch]) begin
                        state <= ST_IDLE;
                        mem_a <= '0;
                    end else if (cnt == len) begin
                        state     <= ST_IDLE;
                        mem_a     <= '0;
                        resp_done <= ONE << ch;
                        resp_data <= rd_next;
                    end else begin
                        rbuf  <= rd_next;
                        cnt   <= cnt_inc;
                        mem_a <= (cnt_inc == len) ? '0 : addr + 32'(cnt_inc);
                    end
                end

                ST_WR: begin
                    if (cnt_inc == len) begin
                        state     <= ST_IDLE;
                        mem_a     <= '0;
                        mem_dout  <= '0;
                        mem_wr    <= 1'b0;
                        resp_done <= ONE << ch;
                        resp_data <= '0;
                    end else if (is_io && io_buffer_full) begin
                        state    <= ST_IOWAIT;
                        cnt      <= cnt_inc;
                        mem_a    <= '0;
                        mem_dout <= '0;
                        mem_wr   <= 1'b0;
                    end else begin
                        cnt      <= cnt_inc;
                        mem_a    <= addr + 32'(cnt_inc);
                        mem_dout <= sel_byte;
                    end
                end

                ST_IOWAIT: begin
                    if (!io_buffer_full) begin
                        state    <= ST_WR;
                        mem_a    <= addr + 32'(cnt);
                        mem_dout <= sel_byte;
                        mem_wr   <= 1'b1;
                    end
                end

                default: begin
                    state    <= ST_IDLE;
                    mem_a    <= '0;
                    mem_dout <= '0;
                    mem_wr   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl_mp.sv
// Scoreboard bench for mem_ctrl_mp (NCH=2, DATA_W=32) with a byte-wide memory model.
module tb_mem_ctrl_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic [1:0]  req_valid;
    logic [1:0]  req_wr;
    logic [63:0] req_addr;
    logic [63:0] req_data;
    logic [5:0]  req_len;
    logic [1:0]  resp_done;
    logic [31:0] resp_data;
    logic        flush;
    logic        io_buffer_full;
    logic [7:0]  mem_din = 8'h00;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    mem_ctrl_mp #(.NCH(2), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr),
        .req_data(req_data), .req_len(req_len),
        .resp_done(resp_done), .resp_data(resp_data),
        .flush(flush), .io_buffer_full(io_buffer_full),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
    );

    always #5 clk = ~clk;

    typedef struct { int ch; logic [63:0] data; bit chk; } resp_t;
    typedef struct { logic [31:0] a; logic [7:0] d; } wr_t;

    resp_t rq[$];
    wr_t   wq[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int t0 = 0;
    int rel = 0;
    int hold_left = 0;
    int last_done_rel = -1;
    int done_rel [2];
    bit done_flag [2];
    logic [31:0] tr_a [64];
    logic        tr_wr [64];
    logic [7:0]  tr_d [64];
    logic [1:0]  tr_done [64];

    logic [7:0] mem [logic [31:0]];

    function automatic logic [7:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a[7:0] ^ 8'h5A;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory: byte returned the cycle after its address, frozen with the rest of the system
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rdy) begin
            mem_din <= mem_rd(mem_a);
            if (mem_wr) mem[mem_a] = mem_dout;
        end
    end

    // Scoreboard: completions and bus writes against expectations queued at issue time
    always @(negedge clk) begin
        if (rst === 1'b1 && resp_done != 2'b00) begin
            if (rq.size() == 0) begin
                check("resp_unexpected", 64'(resp_done), 64'd0);
            end else begin : pop_resp
                resp_t e;
                e = rq.pop_front();
                check("resp_ch", 64'(resp_done), 64'(1) << e.ch);
                if (e.chk) check("resp_data", 64'(resp_data), e.data);
            end
        end
        if (mem_wr === 1'b1) begin
            if (wq.size() == 0) begin
                check("wr_unexpected", 64'(mem_wr), 64'd0);
            end else begin : pop_wr
                wr_t w;
                w = wq.pop_front();
                check("wr_addr", 64'(mem_a), 64'(w.a));
                check("wr_byte", 64'(mem_dout), 64'(w.d));
            end
        end
    end

    task automatic push_rd(input int ch, input logic [31:0] a, input int len);
        resp_t r;
        r.ch = ch; r.chk = 1'b1; r.data = '0;
        for (int k = 0; k < len; k++) r.data[8*k +: 8] = mem_rd(a + 32'(k));
        rq.push_back(r);
    endtask

    task automatic issue(input int ch, input bit wr, input logic [31:0] a,
                         input logic [31:0] d, input int len, input bit exp_done);
        resp_t r;
        req_wr[ch]            = wr;
        req_addr[32*ch +: 32] = a;
        req_data[32*ch +: 32] = d;
        req_len[3*ch +: 3]    = 3'(len);
        req_valid[ch]         = 1'b1;
        done_flag[ch]         = 1'b0;
        if (exp_done) begin
            if (len < 1 || len > 4) begin
                r.ch = ch; r.chk = 1'b1; r.data = '0;
                rq.push_back(r);
            end else if (wr) begin
                for (int k = 0; k < len; k++) wq.push_back('{a + 32'(k), d[8*k +: 8]});
                r.ch = ch; r.chk = 1'b0; r.data = '0;
                rq.push_back(r);
            end else begin
                push_rd(ch, a, len);
            end
        end
    endtask

    task automatic start();
        t0 = cyc;
    endtask

    // One cycle as seen by the clients: trace outputs, drop served requests unless held
    task automatic tick();
        @(negedge clk);
        rel = cyc - t0;
        if (rel >= 0 && rel < 64) begin
            tr_a[rel] = mem_a; tr_wr[rel] = mem_wr; tr_d[rel] = mem_dout; tr_done[rel] = resp_done;
        end
        for (int c = 0; c < 2; c++) begin
            if (resp_done[c]) begin
                done_flag[c] = 1'b1;
                done_rel[c]  = rel;
            end
        end
        if (resp_done != 2'b00) begin
            last_done_rel = rel;
            if (hold_left > 0) begin
                hold_left--;
                if (hold_left == 0) req_valid = 2'b00;
            end else begin
                req_valid = req_valid & ~resp_done;
            end
        end
    endtask

    task automatic wait_done(input int ch, input int limit);
        int n;
        n = 0;
        while (!done_flag[ch] && n < limit) begin
            tick();
            n++;
        end
        if (!done_flag[ch]) check($sformatf("timeout_ch%0d", ch), 64'(done_flag[ch]), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b0; rdy = 1'b1; flush = 1'b0; io_buffer_full = 1'b0;
        req_valid = '0; req_wr = '0; req_addr = '0; req_data = '0; req_len = '0;
        mem[32'h100] = 8'h11; mem[32'h101] = 8'h22; mem[32'h102] = 8'h33; mem[32'h103] = 8'h44;
        repeat (3) @(negedge clk);
        check("rst_mem_a", 64'(mem_a), 64'd0);
        check("rst_mem_wr", 64'(mem_wr), 64'd0);
        check("rst_mem_dout", 64'(mem_dout), 64'd0);
        check("rst_resp_done", 64'(resp_done), 64'd0);
        check("rst_resp_data", 64'(resp_data), 64'd0);
        rst = 1'b1;
        tick();

        // Both channels held from reset: ch0, ch1, ch0
        start();
        hold_left = 3;
        issue(0, 1'b0, 32'h400, 32'h0, 2, 1'b1);
        issue(1, 1'b0, 32'h500, 32'h0, 3, 1'b1);
        push_rd(0, 32'h400, 2);
        n = 0;
        while (hold_left > 0 && n < 60) begin
            tick();
            n++;
        end
        check("alt_remaining", 64'(hold_left), 64'd0);
        check("alt_last_done", 64'(last_done_rel), 64'd13);

        // 4-byte read from 0x100
        repeat (2) tick();
        start();
        issue(0, 1'b0, 32'h100, 32'h0, 4, 1'b1);
        wait_done(0, 20);
        for (int k = 0; k < 4; k++) check($sformatf("rd4_addr%0d", k), 64'(tr_a[1+k]), 64'(32'h100 + 32'(k)));
        check("rd4_done_cycle", 64'(done_rel[0]), 64'd6);

        // IO write stalled by a full UART buffer for 3 cycles
        repeat (2) tick();
        io_buffer_full = 1'b1;
        start();
        issue(1, 1'b1, 32'h30000, 32'hBEEF, 2, 1'b1);
        repeat (3) tick();
        io_buffer_full = 1'b0;
        wait_done(1, 20);
        for (int k = 1; k <= 3; k++) check($sformatf("io_stall_wr%0d", k), 64'(tr_wr[k]), 64'd0);
        check("io_first_addr", 64'(tr_a[4]), 64'h30000);
        check("io_done_cycle", 64'(done_rel[1]), 64'd6);

        // Read aborted by flush at cycle 3, next request granted at cycle 4
        repeat (2) tick();
        start();
        issue(0, 1'b0, 32'h100, 32'h0, 4, 1'b0);
        repeat (3) tick();
        flush = 1'b1;
        req_valid[0] = 1'b0;
        issue(1, 1'b0, 32'h700, 32'h0, 2, 1'b1);
        tick();
        flush = 1'b0;
        wait_done(1, 20);
        check("flush_rd_addr4", 64'(tr_a[4]), 64'd0);
        check("flush_rd_addr5", 64'(tr_a[5]), 64'h700);
        check("flush_rd_next_done", 64'(done_rel[1]), 64'd8);

        // Write ignores flush
        repeat (2) tick();
        start();
        issue(0, 1'b1, 32'h200, 32'hA1B2C3D4, 4, 1'b1);
        repeat (2) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wait_done(0, 20);
        check("flush_wr_done_cycle", 64'(done_rel[0]), 64'd5);

        // rdy low for 5 cycles mid-read
        repeat (2) tick();
        start();
        issue(1, 1'b0, 32'h100, 32'h0, 4, 1'b1);
        repeat (2) tick();
        rdy = 1'b0;
        repeat (5) tick();
        rdy = 1'b1;
        wait_done(1, 30);
        check("pause_addr7", 64'(tr_a[7]), 64'h101);
        check("pause_addr8", 64'(tr_a[8]), 64'h102);
        check("pause_done_cycle", 64'(done_rel[1]), 64'd11);

        // Reset in the middle of a write, then ch0 wins first
        repeat (2) tick();
        start();
        issue(0, 1'b1, 32'h300, 32'hCAFEF00D, 4, 1'b0);
        wq.push_back('{32'h300, 8'h0D});
        wq.push_back('{32'h301, 8'hF0});
        repeat (2) tick();
        rst = 1'b0;
        req_valid = 2'b00;
        tick();
        rst = 1'b1;
        check("midrst_mem_a", 64'(tr_a[3]), 64'd0);
        check("midrst_mem_wr", 64'(tr_wr[3]), 64'd0);
        check("midrst_mem_dout", 64'(tr_d[3]), 64'd0);
        check("midrst_resp_done", 64'(tr_done[3]), 64'd0);
        repeat (2) tick();
        start();
        issue(0, 1'b0, 32'h680, 32'h0, 1, 1'b1);
        issue(1, 1'b0, 32'h600, 32'h0, 1, 1'b1);
        wait_done(0, 20);
        wait_done(1, 20);
        check("prio_ch0_done", 64'(done_rel[0]), 64'd3);
        check("prio_ch1_done", 64'(done_rel[1]), 64'd6);

        // Out-of-range lengths complete without bus traffic
        repeat (2) tick();
        start();
        issue(0, 1'b0, 32'h100, 32'h0, 0, 1'b1);
        wait_done(0, 10);
        check("len0_done_cycle", 64'(done_rel[0]), 64'd1);
        check("len0_no_addr", 64'(tr_a[1]), 64'd0);
        repeat (2) tick();
        start();
        issue(1, 1'b1, 32'h100, 32'h12345678, 5, 1'b1);
        wait_done(1, 10);
        check("len5_done_cycle", 64'(done_rel[1]), 64'd1);
        check("len5_no_write", 64'(tr_wr[1]), 64'd0);

        // Address wraps past 0xFFFFFFFF
        repeat (2) tick();
        start();
        issue(0, 1'b0, 32'hFFFF_FFFF, 32'h0, 2, 1'b1);
        wait_done(0, 20);
        check("wrap_addr1", 64'(tr_a[1]), 64'hFFFF_FFFF);
        check("wrap_addr2", 64'(tr_a[2]), 64'd0);

        repeat (3) tick();
        check("resp_queue_empty", 64'(rq.size()), 64'd0);
        check("wr_queue_empty", 64'(wq.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_ctrl_mp.md
# mem_ctrl_mp

Parametrised multi-channel memory controller between the out-of-order core's memory clients (instruction cache, load/store buffer, extra clients such as a prefetcher) and the 8-bit external memory/IO bus. It arbitrates `NCH` requesters round-robin and serialises each 1..`DATA_W/8`-byte access into single-byte bus cycles. It stalls IO writes while the UART buffer is full and aborts in-flight reads of flushable channels on pipeline rollback.

## Interface
- `NCH`, 2: number of client channels (2..8).
- `DATA_W`, 32: client data width; 32 or 64. `NB = DATA_W/8`, `LW = $clog2(NB)+1`.
- `FLUSH_MASK`, `{NCH{1'b1}}`: bit i set means channel i's reads are abortable by `flush`.
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-low reset.
- `rdy`  in  1  global enable; low freezes all state.
- `req_valid`  in  NCH  per-channel request; held high until that channel's `resp_done`.
- `req_wr`  in  NCH  1 = write, 0 = read.
- `req_addr`  in  NCH*32  byte address, channel i at [32i+31:32i].
- `req_data`  in  NCH*DATA_W  write data, little-endian.
- `req_len`  in  NCH*LW  byte count (1..NB).
- `resp_done`  out  NCH  one-cycle completion pulse to the served channel.
- `resp_data`  out  DATA_W  read data, zero-extended, valid with `resp_done`.
- `flush`  in  1  rollback; aborts masked-channel reads.
- `io_buffer_full`  in  1  UART buffer full.
- `mem_din`  in  8  memory read byte (returned the cycle after its address).
- `mem_dout`  out  8  memory write byte.
- `mem_a`  out  32  memory address.
- `mem_wr`  out  1  1 = write.

## Operation
- States: IDLE, RD, WR, IOWAIT.
- IDLE: grant the first asserted `req_valid` at or after `ptr+1` mod NCH. Latch op, addr, data, len; set `ptr` to the grantee. A masked channel is not granted in a cycle with `flush` high.
- len 0 or > NB: no bus cycles; `resp_done` the next cycle with `resp_data`=0.
- RD: bytes k=0..len-1 drive `mem_a`=addr+k, `mem_wr`=0. Each byte returned on `mem_din` the following cycle goes into `resp_data[8k+7:8k]`; upper bytes are 0.
- WR: `mem_a`=addr+k, `mem_dout`=data[8k+7:8k], `mem_wr`=1.
- An IO address is `addr[17:16]==2'b11`. A write to IO with `io_buffer_full` high goes to IOWAIT: `mem_wr`=0, `mem_a`=0, byte counter held. It returns to WR in the cycle after `io_buffer_full` is seen low.
- Outside RD/WR: `mem_wr`=0, `mem_a`=0, `mem_dout`=0.
- `flush` during RD of a masked channel aborts the read: no `resp_done`, IDLE next cycle, partial data discarded. Writes and unmasked reads always complete. `flush` in the same cycle as the final data byte also aborts.
- `rdy` low: every register (state, counters, outputs, `ptr`) holds. A held `mem_a` re-reads the same byte, so resume is consistent.
- Address arithmetic is 32-bit and wraps modulo 2^32.
- Reset (`rst`=0 at posedge): state IDLE, `ptr`=NCH-1 (channel 0 wins first), `mem_a`=0, `mem_dout`=0, `mem_wr`=0, `resp_done`=0, `resp_data`=0.

## Timing
- Request seen in IDLE at cycle 0.
- Bus byte k appears at cycle 1+k.
- Read of L bytes: last data at cycle L+1; `resp_done` at cycle L+2; IDLE arbitrates again at L+2, so the next op starts at L+3.
- Write of L bytes: `resp_done` at cycle L+1, re-arbitration at L+1.
- All outputs are registered. `resp_done` is exactly one cycle and never asserted for an unserved channel.
- The client must drop or change `req_valid` the cycle after `resp_done`, otherwise the request is re-granted.

## Test plan
- NCH=2: ch0 reads 4 bytes @0x100 (mem bytes 11,22,33,44) -> `mem_a` 0x100..0x103 on cycles 1-4; `resp_done[0]` at cycle 6; `resp_data`=0x44332211.
- ch0 and ch1 both request from reset -> ch0 first, then ch1, then ch0 again. Held requests alternate strictly.
- ch1 writes len 2, data 0xBEEF @0x30000 with `io_buffer_full` high 3 cycles -> no `mem_wr` during stall; then 0xEF then 0xBE at 0x30000/0x30001; single `resp_done[1]`.
- Read len 4; `flush` at cycle 3 -> no `resp_done`; `mem_a`=0 at cycle 4; next request granted at cycle 4.
- Write len 4 with `flush` mid-op -> all 4 bytes written, `resp_done` at cycle 5.
- `rdy` low 5 cycles mid-read, plus `rst` low mid-write -> pause: identical bytes/result, done delayed by 5; reset: all outputs 0 next cycle, IDLE, ch0 priority.
